// File: rtl/reg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg7_pkg
// Description : Shared width and state definitions for the 7-bit serial
//               transmitter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package reg7_pkg;

  localparam int DATA_W = 7;

  // Frame phases of the transmitter
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/reg7_serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and
//               flags the terminal count; clear restarts the period.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  // A single-cycle period still needs a 1-bit counter to keep widths legal
  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_count;

  assign tick = (r_count == c_TERM);

  // Period counter: wraps on terminal count, restarts on clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg7_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : reg7_serial_tx
// Description : Parallel-to-serial transmitter for 7-bit words. Frame is
//               start bit, 7 data bits LSB first, optional even parity, stop.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module reg7_serial_tx
  import reg7_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  tx_state_t         r_state, w_state_n;
  logic [DATA_W-1:0] r_shift, w_shift_n;
  logic [2:0]        r_idx,   w_idx_n;
  logic              r_par,   w_par_n;
  logic              r_tx,    w_tx_n;
  logic              r_ready, w_ready_n;
  logic              r_busy;
  logic              r_done,  w_done_n;
  logic              w_accept;
  logic              w_tick;

  assign w_accept = load && r_ready;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // State, datapath and output registers; tx is loaded with the value of the
  // phase being entered so the line changes exactly on the bit boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_idx   <= w_idx_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_ready <= w_ready_n;
      r_busy  <= ~w_ready_n;
      r_done  <= w_done_n;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_idx_n   = r_idx;
    w_par_n   = r_par;
    w_tx_n    = r_tx;
    w_ready_n = r_ready;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_n    = 1'b1;
        w_ready_n = 1'b1;
        if (w_accept) begin
          w_shift_n = d;
          w_par_n   = ^d;
          w_state_n = START;
          w_tx_n    = 1'b0;
          w_ready_n = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_n = DATA;
          w_idx_n   = '0;
          w_tx_n    = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == 3'(DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              w_state_n = PARITY;
              w_tx_n    = r_par;
            end else begin
              w_state_n = STOP;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_idx_n   = r_idx + 3'd1;
            w_shift_n = r_shift >> 1;
            w_tx_n    = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_n = STOP;
          w_tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_n = IDLE;
          w_tx_n    = 1'b1;
          w_ready_n = 1'b1;
          w_done_n  = 1'b1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_tx_n    = 1'b1;
        w_ready_n = 1'b1;
      end
    endcase
  end

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg7_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg7_serial_tx
// Description : Directed self-checking bench for reg7_serial_tx with a
//               default instance and a no-parity single-cycle-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg7_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] d0, d1;
  logic       load0, load1;
  logic       ready0, tx0, busy0, done0;
  logic       ready1, tx1, busy1, done1;

  int checks = 0;
  int errors = 0;
  logic sb[$];

  always #5 clk = ~clk;

  reg7_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .d(d0), .load(load0),
    .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
  );

  reg7_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk(clk), .reset(reset), .d(d1), .load(load1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic g_tx(input bit w);    return w ? tx1 : tx0;       endfunction
  function automatic logic g_ready(input bit w); return w ? ready1 : ready0; endfunction
  function automatic logic g_busy(input bit w);  return w ? busy1 : busy0;   endfunction
  function automatic logic g_done(input bit w);  return w ? done1 : done0;   endfunction

  task automatic set_load(input bit w, input logic v);
    if (w) load1 = v; else load0 = v;
  endtask

  task automatic set_d(input bit w, input logic [6:0] v);
    if (w) d1 = v; else d0 = v;
  endtask

  // Expected line values of one frame, in transmission order
  task automatic push_frame(input logic [6:0] dv, input int pe);
    sb.push_back(1'b0);
    for (int i = 0; i < 7; i++) sb.push_back(dv[i]);
    if (pe != 0) sb.push_back(^dv);
    sb.push_back(1'b1);
  endtask

  // Called just after a negedge. Accept happens at the next posedge (edge k);
  // ends at the negedge following edge k+N.
  task automatic do_frame(input bit w, input logic [6:0] dv, input int c,
                          input int pe, input bit inject, input bit hold);
    int n;
    logic exp_bit;
    n = (9 + pe) * c;
    check("ready_before_load", g_ready(w), 1'b1);
    set_d(w, dv);
    set_load(w, 1'b1);
    push_frame(dv, pe);
    @(posedge clk);
    #1;
    if (!hold) set_load(w, 1'b0);
    for (int m = 0; m <= n; m++) begin
      @(negedge clk);
      if (m == 0) check("start_immediate", g_tx(w), 1'b0);
      if (m < n && (m % c) == (c / 2)) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
          exp_bit = sb.pop_front();
          check("tx_bit", g_tx(w), exp_bit);
        end
      end
      if (m == n) begin
        check("done_at_n", g_done(w), 1'b1);
        check("ready_at_n", g_ready(w), 1'b1);
        check("busy_at_n", g_busy(w), 1'b0);
        check("tx_idle_at_n", g_tx(w), 1'b1);
      end else begin
        check("done_in_frame", g_done(w), 1'b0);
        check("ready_in_frame", g_ready(w), 1'b0);
        check("busy_in_frame", g_busy(w), 1'b1);
      end
      if (inject && m == 10) begin
        set_d(w, 7'b1010101);
        set_load(w, 1'b1);
      end
      if (inject && m == 11) set_load(w, 1'b0);
    end
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    load0 = 1'b1;
    load1 = 1'b1;
    d0 = 7'h7F;
    d1 = 7'h7F;

    // Reset values, with load held high
    #3;
    check("rst_tx", tx0, 1'b1);
    check("rst_ready", ready0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_tx1", tx1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_tx", tx0, 1'b1);
    check("rst_hold_ready", ready0, 1'b1);
    load0 = 1'b0;
    load1 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", tx0, 1'b1);

    // Single frame with an ignored load at k+10
    do_frame(1'b0, 7'b0000111, 4, 1, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b0) bad++;
    end
    check("no_extra_frame", 8'(bad), 8'd0);

    // Reset mid-frame at k+17
    d0 = 7'b0110011;
    load0 = 1'b1;
    @(posedge clk);
    #1;
    load0 = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_tx", tx0, 1'b1);
    check("midrst_ready", ready0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_done", done0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    check("midrst_no_done", 8'(bad), 8'd0);
    do_frame(1'b0, 7'b1100101, 4, 1, 1'b0, 1'b0);

    // Back-to-back with load held high
    @(negedge clk);
    do_frame(1'b0, 7'h7F, 4, 1, 1'b0, 1'b1);
    do_frame(1'b0, 7'h00, 4, 1, 1'b0, 1'b0);

    // No parity, one clock per bit
    @(negedge clk);
    do_frame(1'b1, 7'h55, 1, 0, 1'b0, 1'b0);
    do_frame(1'b1, 7'h2A, 1, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
